// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data_memory: byte/half extraction with
// extension, sub-word stores by read-modify-write, and access checking.
module load_store_unit #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] write_data,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  store_signal,
   input  logic [31:0] read_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [31:0] DEPTH_W = DEPTH;

   state_t      state, state_nx;
   logic        r_we, r_unsigned;
   logic [1:0]  r_size, r_lane;
   logic [31:0] r_wdata;

   logic        resp_valid_nx, resp_err_nx, mem_read_nx, mem_write_nx;
   logic [31:0] resp_rdata_nx, mem_address_nx, write_data_nx;
   logic        accept, req_bad;

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
      logic [15:0] h;
      logic [7:0]  b;
      h = lane[1] ? w[31:16] : w[15:0];
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      case (size)
         2'b01:   load_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         2'b10:   load_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         default: load_ext = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] size, input logic [1:0] lane);
      merge = w;
      if (size == 2'b01) begin
         if (lane[1]) merge[31:16] = d[15:0];
         else         merge[15:0]  = d[15:0];
      end else begin
         case (lane)
            2'd0:    merge[7:0]   = d[7:0];
            2'd1:    merge[15:8]  = d[7:0];
            2'd2:    merge[23:16] = d[7:0];
            default: merge[31:24] = d[7:0];
         endcase
      end
   endfunction

   assign req_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign store_signal = 2'b00;
   assign accept       = req_valid && (state == IDLE);

   assign req_bad = (req_size == 2'b11)
                 || (req_size == 2'b00 && req_addr[1:0] != 2'b00)
                 || (req_size == 2'b01 && req_addr[0])
                 || ({2'b00, req_addr[31:2]} >= DEPTH_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         r_we        <= 1'b0;
         r_unsigned  <= 1'b0;
         r_size      <= '0;
         r_lane      <= '0;
         r_wdata     <= '0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
         mem_address <= '0;
         write_data  <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
      end else begin
         state       <= state_nx;
         resp_valid  <= resp_valid_nx;
         resp_err    <= resp_err_nx;
         resp_rdata  <= resp_rdata_nx;
         mem_address <= mem_address_nx;
         write_data  <= write_data_nx;
         mem_read    <= mem_read_nx;
         mem_write   <= mem_write_nx;
         if (accept) begin
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      resp_valid_nx  = resp_valid;
      resp_err_nx    = resp_err;
      resp_rdata_nx  = resp_rdata;
      mem_address_nx = mem_address;
      write_data_nx  = write_data;
      mem_read_nx    = 1'b0;
      mem_write_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               resp_rdata_nx = '0;
               resp_err_nx   = req_bad;
               if (req_bad) begin
                  resp_valid_nx = 1'b1;
                  state_nx      = RESP;
               end else begin
                  mem_address_nx = {2'b00, req_addr[31:2]};
                  if (req_we && req_size == 2'b00) begin
                     write_data_nx = req_wdata;
                     mem_write_nx  = 1'b1;
                     state_nx      = WR;
                  end else begin
                     mem_read_nx = 1'b1;
                     state_nx    = RD;
                  end
               end
            end
         end
         // read_data is valid this cycle: finish a load, or merge for a sub-word store
         RD: begin
            if (r_we) begin
               write_data_nx = merge(read_data, r_wdata, r_size, r_lane);
               mem_write_nx  = 1'b1;
               state_nx      = WR;
            end else begin
               resp_rdata_nx = load_ext(read_data, r_size, r_lane, r_unsigned);
               resp_valid_nx = 1'b1;
               state_nx      = RESP;
            end
         end
         WR: begin
            resp_valid_nx = 1'b1;
            state_nx      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_nx = 1'b0;
               state_nx      = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
